// File: rtl/memory_arbiter.sv
`default_nettype none
// ============================================================================
// memory_arbiter: shares one RAM port between instruction and data accesses,
// with alternating grants under contention and a sticky RAM-timeout trap.
// Revision: 1.0
// ============================================================================
module memory_arbiter #(
   parameter int TIMEOUT = 255,
   parameter int CW      = 8
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        iren,
   input  logic [31:0] iaddr,
   input  logic        dren,
   input  logic        dwen,
   input  logic [31:0] daddr,
   input  logic [31:0] dstore,
   output logic        ihit,
   output logic        dhit,
   output logic [31:0] iload,
   output logic [31:0] dload,
   output logic        ramren,
   output logic        ramwen,
   output logic [31:0] ramaddr,
   output logic [31:0] ramstore,
   input  logic [31:0] ramload,
   input  logic        ramready,
   output logic        err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DACC = 2'd1,
      IACC = 2'd2,
      ERR  = 2'd3
   } state_t;

   localparam logic [CW-1:0] C_CNT_MAX = CW'(TIMEOUT - 1);

   generate
      if (TIMEOUT < 1 || TIMEOUT > 255 || (2 ** CW) <= TIMEOUT) begin : g_bad_params
         $error("memory_arbiter: TIMEOUT must be 1..255 and fit in CW bits");
      end
   endgenerate

   state_t          r_state;
   state_t          w_next;
   logic            r_wr;
   logic [31:0]     r_addr;
   logic [31:0]     r_store;
   logic [CW-1:0]   r_cnt;
   logic [CW-1:0]   w_cnt_next;
   logic            r_last_grant;
   logic            r_err;
   logic            w_dreq;
   logic            w_grant_d;
   logic            w_grant_i;

   // A simultaneous read and write request is handled as a write.
   assign w_dreq = dren | dwen;
   assign err    = r_err;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state      <= IDLE;
         r_cnt        <= '0;
         r_last_grant <= 1'b0;
         r_err        <= 1'b0;
         r_wr         <= 1'b0;
         r_addr       <= '0;
         r_store      <= '0;
      end else begin
         r_state <= w_next;
         r_cnt   <= w_cnt_next;
         if (w_grant_d) begin
            r_wr    <= dwen;
            r_addr  <= daddr;
            r_store <= dstore;
         end else if (w_grant_i) begin
            r_wr    <= 1'b0;
            r_addr  <= iaddr;
         end
         if (dhit) begin
            r_last_grant <= 1'b1;
         end else if (ihit) begin
            r_last_grant <= 1'b0;
         end
         if (w_next == ERR) begin
            r_err <= 1'b1;
         end
      end
   end

   always_comb begin
      w_next     = r_state;
      w_grant_d  = 1'b0;
      w_grant_i  = 1'b0;
      w_cnt_next = '0;
      ihit       = 1'b0;
      dhit       = 1'b0;
      iload      = '0;
      dload      = '0;
      ramren     = 1'b0;
      ramwen     = 1'b0;
      ramaddr    = '0;
      ramstore   = '0;
      case (r_state)
         IDLE: begin
            // Under contention the side that did not complete last wins.
            if (w_dreq && (!iren || !r_last_grant)) begin
               w_grant_d = 1'b1;
               w_next    = DACC;
            end else if (iren) begin
               w_grant_i = 1'b1;
               w_next    = IACC;
            end
         end
         DACC: begin
            ramaddr  = r_addr;
            ramren   = ~r_wr;
            ramwen   = r_wr;
            ramstore = r_wr ? r_store : '0;
            if (!w_dreq) begin
               w_next = IDLE;
            end else if (ramready) begin
               dhit   = 1'b1;
               dload  = ramload;
               w_next = IDLE;
            end else if (r_cnt == C_CNT_MAX) begin
               w_next = ERR;
            end else begin
               w_cnt_next = r_cnt + CW'(1);
            end
         end
         IACC: begin
            ramaddr = r_addr;
            ramren  = 1'b1;
            if (!iren) begin
               w_next = IDLE;
            end else if (ramready) begin
               ihit   = 1'b1;
               iload  = ramload;
               w_next = IDLE;
            end else if (r_cnt == C_CNT_MAX) begin
               w_next = ERR;
            end else begin
               w_cnt_next = r_cnt + CW'(1);
            end
         end
         ERR: begin
            w_next = ERR;
         end
         default: begin
            w_next = IDLE;
         end
      endcase
   end

endmodule
`default_nettype wire
